// File: rtl/encoder_8to3.sv
// Registered priority encoder: reduces a request vector to the index of its
// highest set bit, with a valid flag that separates "no request" from request 0.
module encoder_8to3 #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic [OUT_W-1:0] dout,
  output logic             valid
);

  logic [OUT_W-1:0] enc_idx;
  logic             enc_any;

  // Ascending scan so the last (highest) set bit overwrites any lower ones.
  always_comb begin
    enc_idx = '0;
    enc_any = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) begin
        enc_idx = OUT_W'(i);
        enc_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (en) begin
      dout  <= enc_idx;
      valid <= enc_any;
    end
  end

endmodule

// File: tb/tb_encoder_8to3.sv
// Directed-vector bench for encoder_8to3: reset, one-hot sweep, priority,
// zero input, enable hold and an asynchronous reset pulse mid-sweep.
module tb_encoder_8to3;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       en;
  logic [2:0] dout;
  logic       valid;

  int vectors     = 0;
  int miscompares = 0;

  encoder_8to3 #(.WIDTH(8), .OUT_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .en    (en),
    .dout  (dout),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] exp_dout, input logic exp_valid);
    check({tag, ".dout"}, {5'd0, dout}, {5'd0, exp_dout});
    check({tag, ".valid"}, {7'd0, valid}, {7'd0, exp_valid});
  endtask

  // Drive on the falling edge, check just after the next rising edge.
  task automatic step(input string tag, input logic [7:0] d, input logic e,
                      input logic [2:0] exp_dout, input logic exp_valid);
    @(negedge clk);
    din = d;
    en  = e;
    @(posedge clk);
    #1;
    check_out(tag, exp_dout, exp_valid);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    din = 8'hFF;
    en  = 1'b1;
    #3;
    check_out("rst_async", 3'd0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_out("rst_hold", 3'd0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_out("rst_release", 3'd7, 1'b1);

    step("hot80", 8'h80, 1'b1, 3'd7, 1'b1);
    step("hot40", 8'h40, 1'b1, 3'd6, 1'b1);
    step("hot20", 8'h20, 1'b1, 3'd5, 1'b1);
    step("hot10", 8'h10, 1'b1, 3'd4, 1'b1);

    // Reset pulse entirely between two rising edges, with the next input already driven.
    @(negedge clk);
    din = 8'h08;
    #2 rst = 1'b1;
    #1 check_out("rst_mid", 3'd0, 1'b0);
    #1 rst = 1'b0;
    #0.5 check_out("rst_mid_low", 3'd0, 1'b0);
    @(posedge clk);
    #1;
    check_out("hot08_resume", 3'd3, 1'b1);

    step("hot04", 8'h04, 1'b1, 3'd2, 1'b1);
    step("hot02", 8'h02, 1'b1, 3'd1, 1'b1);
    step("hot01", 8'h01, 1'b1, 3'd0, 1'b1);

    step("pri25", 8'b0010_0101, 1'b1, 3'd5, 1'b1);
    step("priFF", 8'hFF, 1'b1, 3'd7, 1'b1);
    step("pri03", 8'b0000_0011, 1'b1, 3'd1, 1'b1);

    step("zero", 8'h00, 1'b1, 3'd0, 1'b0);
    step("one", 8'h01, 1'b1, 3'd0, 1'b1);
    step("zero_again", 8'h00, 1'b1, 3'd0, 1'b0);

    step("hold_load", 8'h10, 1'b1, 3'd4, 1'b1);
    step("hold1", 8'h02, 1'b0, 3'd4, 1'b1);
    step("hold2", 8'h02, 1'b0, 3'd4, 1'b1);
    step("hold3", 8'h02, 1'b0, 3'd4, 1'b1);
    step("hold_release", 8'h02, 1'b1, 3'd1, 1'b1);

    // Input changes between edges must not reach the outputs.
    @(negedge clk);
    din = 8'h40;
    #2 din = 8'h00;
    #1 check_out("mid_change", 3'd1, 1'b1);
    @(posedge clk);
    #1;
    check_out("mid_change_edge", 3'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
